// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch/LSU requesters, the arbiter and the byte-lane `mem`.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  i_valid;
    logic                  i_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rsp_valid;
    logic [31:0]           i_rdata;

    logic                  d_valid;
    logic                  d_ready;
    logic                  d_we;
    logic [1:0]            d_size;
    logic                  d_unsigned;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic                  d_rsp_valid;
    logic [31:0]           d_rdata;
    logic                  d_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_wenableL;
    logic [3:0][7:0]       mem_data_w;
    logic [3:0][7:0]       mem_data_r;

    modport slave (
        input  i_valid, i_addr, d_valid, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_data_r,
        output i_ready, i_rsp_valid, i_rdata, d_ready, d_rsp_valid, d_rdata, d_err,
        output mem_addr, mem_wenableL, mem_data_w
    );

    modport master (
        output i_valid, i_addr, d_valid, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_data_r,
        input  i_ready, i_rsp_valid, i_rdata, d_ready, d_rsp_valid, d_rdata, d_err,
        input  mem_addr, mem_wenableL, mem_data_w
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port byte-lane memory between a fetch port
// and a load/store port, with lane steering, byte enables, load extension and misalign errors.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH       = 12,
    parameter int unsigned DATA_WIDTH_BYTES = 4
) (
    input logic          clk,
    input logic          rstL,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StError} state_e;

    state_e                      r_state;
    logic                        r_last_d;
    logic                        r_is_d;
    logic                        r_we;
    logic                        r_uns;
    logic [1:0]                  r_size;
    logic [1:0]                  r_off;
    logic [ADDR_WIDTH-1:0]       r_mem_addr;
    logic [DATA_WIDTH_BYTES-1:0] r_mem_wen;
    logic [31:0]                 r_mem_data_w;
    logic                        r_i_rsp_valid;
    logic [31:0]                 r_i_rdata;
    logic                        r_d_rsp_valid;
    logic [31:0]                 r_d_rdata;
    logic                        r_d_err;

    logic                        w_idle;
    logic                        w_grant_d;
    logic                        w_grant_i;
    logic                        w_accept_d;
    logic                        w_accept_i;
    logic [ADDR_WIDTH-1:0]       w_req_addr;
    logic                        w_misaligned;
    logic [DATA_WIDTH_BYTES-1:0] w_be;
    logic [31:0]                 w_wdata_sh;
    logic [31:0]                 w_rd_word;
    logic [31:0]                 w_lane;
    logic [31:0]                 w_load_ext;

    // Tie goes to whichever port was not served last.
    assign w_idle     = (r_state == StIdle);
    assign w_grant_d  = bus.d_valid && (!bus.i_valid || !r_last_d);
    assign w_grant_i  = bus.i_valid && !w_grant_d;
    assign w_accept_d = w_idle && w_grant_d;
    assign w_accept_i = w_idle && w_grant_i;
    assign w_req_addr = w_grant_d ? bus.d_addr : bus.i_addr;

    assign bus.d_ready = w_accept_d;
    assign bus.i_ready = w_accept_i;

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        case (bus.d_size)
            2'b00: w_be = 4'b0001 << bus.d_addr[1:0];
            2'b01: begin
                w_be         = 4'b0011 << {bus.d_addr[1], 1'b0};
                w_misaligned = bus.d_addr[0];
            end
            2'b10: w_misaligned = (bus.d_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_wdata_sh = bus.d_wdata << {bus.d_addr[1:0], 3'b000};
    assign w_rd_word  = bus.mem_data_r;
    assign w_lane     = w_rd_word >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_load_ext = {{24{!r_uns && w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load_ext = {{16{!r_uns && w_lane[15]}}, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            r_state       <= StIdle;
            r_last_d      <= 1'b0;
            r_is_d        <= 1'b0;
            r_we          <= 1'b0;
            r_uns         <= 1'b0;
            r_size        <= 2'b00;
            r_off         <= 2'b00;
            r_mem_addr    <= '0;
            r_mem_wen     <= '1;
            r_mem_data_w  <= '0;
            r_i_rsp_valid <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rdata     <= '0;
            r_d_err       <= 1'b0;
        end else begin
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_d_err       <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept_d || w_accept_i) begin
                        r_last_d <= w_accept_d;
                        r_is_d   <= w_accept_d;
                        r_we     <= w_accept_d && bus.d_we;
                        r_size   <= bus.d_size;
                        r_uns    <= bus.d_unsigned;
                        r_off    <= w_req_addr[1:0];
                        if (w_accept_d && w_misaligned) begin
                            // Error pulse is raised on entry so it lands one cycle after accept.
                            r_state       <= StError;
                            r_d_rsp_valid <= 1'b1;
                            r_d_err       <= 1'b1;
                            r_d_rdata     <= '0;
                        end else begin
                            r_state    <= StAccess;
                            r_mem_addr <= {w_req_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (w_accept_d && bus.d_we) begin
                                r_mem_wen    <= ~w_be;
                                r_mem_data_w <= w_wdata_sh;
                            end
                        end
                    end
                end
                StAccess: begin
                    r_mem_wen <= '1;
                    if (r_we) begin
                        r_state       <= StIdle;
                        r_d_rsp_valid <= 1'b1;
                        r_d_rdata     <= '0;
                    end else begin
                        r_state <= StCapture;
                    end
                end
                StCapture: begin
                    r_state <= StIdle;
                    if (r_is_d) begin
                        r_d_rsp_valid <= 1'b1;
                        r_d_rdata     <= w_load_ext;
                    end else begin
                        r_i_rsp_valid <= 1'b1;
                        r_i_rdata     <= w_rd_word;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wenableL = r_mem_wen;
    assign bus.mem_data_w   = r_mem_data_w;
    assign bus.i_rsp_valid  = r_i_rsp_valid;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_rsp_valid  = r_d_rsp_valid;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_err        = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory stand-in, transaction-level reference model checked
// every cycle, and directed requests with hand-computed literal expectations.
module tb_mem_arbiter;

    logic clk;
    logic rstL;

    mem_arbiter_if #(.ADDR_WIDTH(12)) bus ();

    mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH_BYTES(4)) dut (
        .clk (clk),
        .rstL(rstL),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Memory stand-in: write lanes and register the addressed word at the same edge.
    logic [7:0] bmem    [0:4095];
    logic [7:0] ref_mem [0:4095];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            bmem[i]    = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
    end

    always @(posedge clk) begin
        int a;
        a = int'({bus.mem_addr[11:2], 2'b00});
        for (int k = 0; k < 4; k++)
            if (!bus.mem_wenableL[k]) bmem[a + k] <= bus.mem_data_w[k];
        bus.mem_data_r <= {bmem[a + 3], bmem[a + 2], bmem[a + 1], bmem[a]};
    end

    // Little-endian gather of nb bytes, then zero or sign extension by arithmetic.
    function automatic logic [31:0] load_val(input int a, input int size, input bit uns);
        int     nb;
        longint v;
        nb = 1 << size;
        v  = 0;
        for (int k = nb - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[a + k]);
        if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // Reference model: one outstanding transaction, timed by accept-relative cycle offsets.
    int          mc = 0;
    int          busy_until = 0;
    bit          last_d = 1'b0;
    bit          p_act = 1'b0;
    int          p_e0, p_addr, p_size;
    bit          p_isd, p_we, p_uns, p_err;
    logic [31:0] p_wdata, p_rdata;
    logic [31:0] m_i_rdata = '0;
    logic [31:0] m_d_rdata = '0;

    always @(negedge clk) begin
        logic [3:0] e_wen;
        bit         e_irsp, e_drsp, e_derr, e_ir, e_dr, gd;
        int         rsp_c, nb, off, m;
        mc++;
        e_wen  = 4'hF;
        e_irsp = 1'b0;
        e_drsp = 1'b0;
        e_derr = 1'b0;
        if (!rstL) begin
            p_act      = 1'b0;
            busy_until = 0;
            last_d     = 1'b0;
            m_i_rdata  = '0;
            m_d_rdata  = '0;
        end
        if (p_act) begin
            nb    = 1 << p_size;
            off   = p_addr % 4;
            m     = ((1 << nb) - 1) << off;
            rsp_c = p_err ? p_e0 : (p_we ? p_e0 + 1 : p_e0 + 2);
            if (mc == p_e0 && !p_err) begin
                chk("model_mem_addr", 32'(bus.mem_addr), 32'(p_addr - off));
                if (p_we) begin
                    e_wen = ~m[3:0];
                    for (int k = 0; k < 4; k++)
                        if (m[k]) chk("model_store_lane", 32'(bus.mem_data_w[k]),
                                      (p_wdata >> (8 * (k - off))) & 32'hFF);
                end
            end
            if (p_we && !p_err && mc == p_e0 + 1)
                for (int k = 0; k < nb; k++) ref_mem[p_addr + k] = 8'(p_wdata >> (8 * k));
            if (mc == rsp_c) begin
                if (p_isd) begin
                    e_drsp    = 1'b1;
                    e_derr    = p_err;
                    m_d_rdata = p_rdata;
                end else begin
                    e_irsp    = 1'b1;
                    m_i_rdata = p_rdata;
                end
                p_act = 1'b0;
            end
        end
        gd   = bus.d_valid && (!bus.i_valid || !last_d);
        e_dr = (mc >= busy_until) && gd;
        e_ir = (mc >= busy_until) && bus.i_valid && !gd;
        chk("model_d_ready", 32'(bus.d_ready), 32'(e_dr));
        chk("model_i_ready", 32'(bus.i_ready), 32'(e_ir));
        chk("model_wenableL", 32'(bus.mem_wenableL), 32'(e_wen));
        chk("model_i_rsp_valid", 32'(bus.i_rsp_valid), 32'(e_irsp));
        chk("model_d_rsp_valid", 32'(bus.d_rsp_valid), 32'(e_drsp));
        chk("model_d_err", 32'(bus.d_err), 32'(e_derr));
        chk("model_i_rdata", bus.i_rdata, m_i_rdata);
        chk("model_d_rdata", bus.d_rdata, m_d_rdata);
        if (rstL && (e_dr || e_ir)) begin
            p_act   = 1'b1;
            p_e0    = mc + 1;
            p_isd   = e_dr;
            last_d  = e_dr;
            p_addr  = e_dr ? int'(bus.d_addr) : int'(bus.i_addr);
            p_we    = e_dr && bus.d_we;
            p_size  = e_dr ? int'(bus.d_size) : 2;
            p_uns   = e_dr ? bus.d_unsigned : 1'b1;
            p_wdata = bus.d_wdata;
            p_err   = e_dr && (bus.d_size == 2'b11 || (p_addr % (1 << bus.d_size)) != 0);
            if (p_err || p_we) p_rdata = '0;
            else if (e_dr)     p_rdata = load_val(p_addr, p_size, p_uns);
            else               p_rdata = load_val(p_addr - (p_addr % 4), 2, 1'b1);
            busy_until = p_e0 + ((p_err || p_we) ? 1 : 2);
        end
    end

    task automatic do_req(input bit is_d, input bit we, input logic [1:0] size, input bit uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit err, output int lat,
                          output logic [3:0] wen_seen, output logic [7:0] lane3);
        bit got;
        @(posedge clk);
        #1;
        if (is_d) begin
            bus.d_valid    = 1'b1;
            bus.d_we       = we;
            bus.d_size     = size;
            bus.d_unsigned = uns;
            bus.d_addr     = addr;
            bus.d_wdata    = wdata;
        end else begin
            bus.i_valid = 1'b1;
            bus.i_addr  = addr;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = is_d ? bus.d_ready : bus.i_ready;
        end
        chk("req_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.d_valid = 1'b0;
        bus.i_valid = 1'b0;
        lat      = 0;
        wen_seen = 4'hF;
        lane3    = '0;
        got      = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_wenableL != 4'hF) begin
                wen_seen = bus.mem_wenableL;
                lane3    = bus.mem_data_w[3];
            end
            got = is_d ? bus.d_rsp_valid : bus.i_rsp_valid;
        end
        chk("rsp_seen", 32'(got), 32'd1);
        rdata = is_d ? bus.d_rdata : bus.i_rdata;
        err   = bus.d_err;
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat;
        logic [3:0]  ws;
        logic [7:0]  l3;
        bit          g_d [6];
        int          g_t [6];
        int          n, cc;
        bit          got;

        rstL           = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_addr     = '0;
        bus.d_valid    = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_size     = 2'b00;
        bus.d_unsigned = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wenableL", 32'(bus.mem_wenableL), 32'hF);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_data_w", bus.mem_data_w, 32'h0);
        chk("rst_rsp", 32'({bus.i_rsp_valid, bus.d_rsp_valid, bus.d_err}), 32'h0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        rstL = 1'b1;

        do_req(1, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, rd, er, lat, ws, l3);
        chk("st_word_wen", 32'(ws), 32'h0);
        chk("st_word_lat", 32'(lat), 32'd2);
        do_req(0, 0, 2'b10, 0, 12'h010, 32'h0, rd, er, lat, ws, l3);
        chk("fetch_word", rd, 32'hDEADBEEF);
        chk("fetch_lat", 32'(lat), 32'd3);

        do_req(1, 1, 2'b00, 0, 12'h013, 32'h00000080, rd, er, lat, ws, l3);
        chk("st_byte_wen", 32'(ws), 32'h7);
        chk("st_byte_lane3", 32'(l3), 32'h80);
        do_req(1, 0, 2'b00, 0, 12'h013, 32'h0, rd, er, lat, ws, l3);
        chk("ld_byte_signed", rd, 32'hFFFFFF80);
        chk("ld_lat", 32'(lat), 32'd3);
        do_req(1, 0, 2'b00, 1, 12'h013, 32'h0, rd, er, lat, ws, l3);
        chk("ld_byte_unsigned", rd, 32'h00000080);

        do_req(1, 1, 2'b01, 0, 12'h022, 32'h00001234, rd, er, lat, ws, l3);
        chk("st_half_wen", 32'(ws), 32'h3);
        do_req(1, 0, 2'b01, 0, 12'h022, 32'h0, rd, er, lat, ws, l3);
        chk("ld_half_signed", rd, 32'h00001234);
        do_req(1, 0, 2'b01, 0, 12'h012, 32'h0, rd, er, lat, ws, l3);
        chk("ld_half_neg", rd, 32'hFFFF80AD);

        do_req(1, 0, 2'b10, 0, 12'h011, 32'h0, rd, er, lat, ws, l3);
        chk("mis_word_err", 32'(er), 32'd1);
        chk("mis_word_lat", 32'(lat), 32'd1);
        do_req(1, 1, 2'b01, 0, 12'h021, 32'h0000FFFF, rd, er, lat, ws, l3);
        chk("mis_half_err", 32'(er), 32'd1);
        chk("mis_half_wen", 32'(ws), 32'hF);
        do_req(1, 0, 2'b11, 0, 12'h014, 32'h0, rd, er, lat, ws, l3);
        chk("mis_size3_err", 32'(er), 32'd1);
        do_req(0, 0, 2'b10, 0, 12'h020, 32'h0, rd, er, lat, ws, l3);
        chk("mis_readback", rd, 32'h12347B7A);

        // Contention: both ports held valid for six grants.
        @(posedge clk);
        #1;
        bus.i_valid    = 1'b1;
        bus.i_addr     = 12'h020;
        bus.d_valid    = 1'b1;
        bus.d_we       = 1'b0;
        bus.d_size     = 2'b10;
        bus.d_unsigned = 1'b0;
        bus.d_addr     = 12'h010;
        n  = 0;
        cc = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            @(negedge clk);
            cc++;
            if (bus.d_ready || bus.i_ready) begin
                g_d[n] = bus.d_ready;
                g_t[n] = cc;
                n++;
            end
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        chk("cont_grants", 32'(n), 32'd6);
        for (int k = 0; k < n; k++) begin
            chk("cont_order", 32'(g_d[k]), 32'((k % 2) == 0));
            if (k > 0) chk("cont_gap_ge3", 32'(g_t[k] - g_t[k - 1] >= 3), 32'd1);
        end
        repeat (5) @(negedge clk);

        // Async reset while a store is in its write cycle.
        @(posedge clk);
        #1;
        bus.d_valid    = 1'b1;
        bus.d_we       = 1'b1;
        bus.d_size     = 2'b10;
        bus.d_addr     = 12'h030;
        bus.d_wdata    = 32'hCAFEF00D;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.d_ready;
        end
        chk("abort_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.d_valid = 1'b0;
        chk("abort_wen_active", 32'(bus.mem_wenableL), 32'h0);
        #2;
        rstL = 1'b0;
        #1;
        chk("abort_wen_async", 32'(bus.mem_wenableL), 32'hF);
        chk("abort_no_rsp", 32'(bus.d_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rstL = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp_after", 32'(bus.d_rsp_valid), 32'd0);
        end
        do_req(0, 0, 2'b10, 0, 12'h030, 32'h0, rd, er, lat, ws, l3);
        chk("abort_unchanged", rd, 32'h69686B6A);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port byte-lane `mem` block. It shares `mem` between the instruction-fetch port (I, read-only) and the load/store port (D, read/write with byte/half/word size). It also handles lane steering, byte-enable generation, load extension and misalignment detection. It sits between the core's fetch/LSU and `mem`.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width shared with `mem`
- DATA_WIDTH_BYTES, 4, lanes per `mem` word; only 4 is supported

Ports:
- clk  in  1  system clock, all state on rising edge
- rstL  in  1  asynchronous active-low reset
- i_valid  in  1  fetch request
- i_ready  out  1  fetch request accepted this cycle
- i_addr  in  ADDR_WIDTH  fetch byte address; must be word aligned
- i_rsp_valid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  32  fetched word
- d_valid  in  1  load/store request
- d_ready  out  1  load/store request accepted this cycle
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned
- d_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- d_addr  in  ADDR_WIDTH  byte address
- d_wdata  in  32  store data, LSB-justified
- d_rsp_valid  out  1  one-cycle pulse, load data valid or store done
- d_rdata  out  32  extended load data; 0 for stores
- d_err  out  1  qualifies d_rsp_valid: misaligned access, no memory effect
- mem_addr  out  ADDR_WIDTH  to `mem` addr, low 2 bits always 0
- mem_wenableL  out  [3:0]  to `mem` wenableL, per-lane active-low write enable
- mem_data_w  out  8 x [3:0]  to `mem` data_w, lane k = byte at address+k
- mem_data_r  in  8 x [3:0]  from `mem` data_r

## Operation
- `mem` contract: it samples addr, wenableL and data_w at a rising edge. data_r for that addr is registered out after the same edge.
- FSM states: IDLE, ACCESS, CAPTURE, ERROR.
- IDLE: grant is combinational from the valids.
  - Exactly one valid: that port wins.
  - Both valid: the port not granted last wins (round-robin). After reset, last = I, so D wins the first tie.
  - Winner's ready is high; the loser's ready is low. Accept is valid&&ready at the edge.
  - Accepted misaligned D request goes to ERROR.
  - Accepted read goes to ACCESS; accepted store goes to ACCESS.
- ACCESS: drive mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Store: mem_wenableL lanes low per size/offset. Byte: lane a[1:0]. Half: lanes a[1]*2, a[1]*2+1. Word: all four.
  - Store: mem_data_w holds d_wdata replicated/shifted so the low byte sits in lane a[1:0].
  - Store next state: IDLE with d_rsp_valid=1, d_err=0, d_rdata=0.
  - Read next state: CAPTURE.
- CAPTURE: register mem_data_r, then go to IDLE with the port's rsp_valid=1.
  - I: i_rdata = {lane3,lane2,lane1,lane0}.
  - D: select lane(s) at offset, then extend to 32 bits per d_size/d_unsigned.
- ERROR: set d_rsp_valid=1 and d_err=1 for one cycle, with no mem_wenableL activity, then go to IDLE.
- Misaligned: half with a[0]=1; word with a[1:0]≠0; size 11. Misaligned I addresses are not checked; the low bits are ignored.
- Address, size and data are latched at accept; requesters may change inputs afterwards.
- mem_wenableL is 4'b1111 in every state except ACCESS for a store.
- No new accept outside IDLE: both readies are 0 in ACCESS, CAPTURE and ERROR.

## Timing
- Reset (async, immediate): state IDLE, last-grant I, mem_wenableL=4'b1111, mem_addr=0, mem_data_w=0, all rsp_valid/err=0, i_rdata=d_rdata=0. Ready follows IDLE grant logic.
- rstL low mid-operation aborts the access. No rsp pulse is issued, and a store in ACCESS is suppressed as wenableL goes high asynchronously.
- Load/fetch: accept edge E0, ACCESS after E0, CAPTURE after E1, rsp_valid high after E2.
  - Latency is 3 cycles accept-to-rsp.
  - Next accept is possible at E3, in the IDLE cycle that carries the rsp pulse. Throughput is one read per 3 cycles.
- Store: accept E0, wenableL low after E0 for one cycle (`mem` writes at E1), d_rsp_valid after E1. Throughput is one store per 2 cycles.
- Misaligned: accept E0, d_rsp_valid+d_err after E0.
- rsp pulses last exactly one cycle; rdata holds until the next response on that port.

## Test plan
- After reset: D store word 0xDEADBEEF to addr 0x010, then I fetch 0x010. Expect wenableL=0000 for one cycle and i_rdata=0xDEADBEEF 3 cycles after accept.
- Byte lanes:
  - Store byte 0x80 to 0x013: wenableL=0111 and lane3=0x80.
  - Signed byte load from 0x013: d_rdata=0xFFFFFF80.
  - Unsigned byte load from 0x013: d_rdata=0x00000080.
- Halfword: store 0x1234 to 0x022, then load signed from 0x022. Expect wenableL=0011 and d_rdata=0x00001234.
- Misaligned: word load at 0x011 and half store at 0x021. Expect d_err pulse 1 cycle after accept, wenableL stays 1111, and memory is unchanged on readback.
- Contention: i_valid and d_valid held high for 6 grants. Expect order D,I,D,I,D,I with no two accepts closer than the access latency.
- Async reset: rstL pulsed low during ACCESS of a store. Expect wenableL=1111 immediately, no d_rsp_valid, and the target word unchanged.
